mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles, using one shared memory port for both instruction and data. It drives every datapath mux select and write enable, and decodes ALU control from opcode and funct. It sits inside the core next to the datapath, with the same top-level memwrite/dataadr/writedata memory interface.

Parameters:
RESET_STATE, 4'd0, state encoding entered on reset (FETCH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pcen  output  1  PC register enable
irwrite  output  1  instruction register load
regwrite  output  1  register file write
memwrite  output  1  data memory write strobe
iord  output  1  memory address select: 0=PC, 1=ALUOut
regdst  output  1  write register select: 0=rt, 1=rd
memtoreg  output  1  writeback select: 0=ALUOut, 1=Data
alusrca  output  1  ALU A select: 0=PC, 1=regA
alusrcb  output  2  ALU B select: 00=regB, 01=4, 10=signimm, 11=signimm<<2
pcsrc  output  2  PC select: 00=ALU, 01=ALUOut, 10=jump target
alucontrol  output  3  ALU operation
illegal  output  1  one-cycle pulse on an unsupported opcode or funct
state  output  4  current state, for debug

Behaviour:
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXECUTE(6), ALUWB(7), BRANCH(8), ADDIEXEC(9), ADDIWB(10), JUMP(11). Codes 12–15 are unreachable and go to FETCH.
- Reset: while rst=0, state=FETCH asynchronously. pcen, irwrite, regwrite, memwrite and illegal are forced to 0. The first fetch begins on the first rising edge after rst rises. Reset during any state aborts the instruction with no partial write.
- FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00.
  - If mem_ready=0: irwrite=pcen=0 and the FSM stays in FETCH.
  - If mem_ready=1: irwrite=1, pcen=1, next state DECODE.
- DECODE: alusrca=0, alusrcb=11, add (computes the branch target). Next state by op:
  - 100011 lw → MEMADR
  - 101011 sw → MEMADR
  - 000000 R-type → EXECUTE
  - 000100 beq → BRANCH
  - 001000 addi → ADDIEXEC
  - 000010 j → JUMP
  - any other op → FETCH with illegal=1 for one cycle
- MEMADR: alusrca=1, alusrcb=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Wait until mem_ready=1, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, then FETCH.
- MEMWR: iord=1, memwrite=1 held every cycle until mem_ready=1, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, then ALUWB. alucontrol by funct:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other funct → illegal=1, alucontrol=010, then FETCH (no writeback)
- ALUWB: regdst=1, memtoreg=0, regwrite=1, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero, then FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, add, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, then FETCH.
- JUMP: pcsrc=10, pcen=1, then FETCH.
- Outputs not listed for a state default to 0; alucontrol defaults to 010.
- Output timing: outputs are combinational from the registered state, except irwrite/pcen (FETCH, BRANCH) and memwrite/illegal, which depend on the current-cycle inputs.
- Cycle counts with mem_ready tied to 1:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3

Test Plan:
- rst=0 for 10 cycles, then release, mem_ready=1 → state=0 throughout reset with all enables 0; irwrite=pcen=1 on the first cycle after release.
- lw (op=100011), mem_ready=1 → states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; exactly 5 cycles.
- sw, with mem_ready held 0 for 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, then state returns to 0; regwrite never asserted.
- R-type funct=100010 → alucontrol=110 in EXECUTE; regwrite=1, regdst=1 in ALUWB. funct=000111 → illegal pulse, no regwrite.
- beq with zero=1 → pcen=1, pcsrc=01 in state 8. Same with zero=0 → pcen=0. j → pcsrc=10, pcen=1 in state 11.
- op=111111 in DECODE → illegal=1 for one cycle, next state FETCH. Drive rst=0 mid-MEMWR → memwrite drops immediately and state=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback over a single shared memory port.
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= state_t'(RESET_STATE);
    else      state_q <= state_d;
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      // Write strobe stays up for the whole access, including the ready cycle.
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        if (funct_ok) begin
          alucontrol = funct_alu;
          state_d    = S_ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Held in reset the FSM sits in FETCH, so mask every side effect.
    if (!rst) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: stimulus pushes hand-computed per-cycle
// output vectors into a scoreboard queue; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [19:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [19:0] act;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;

  mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  assign act = {state, pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, alucontrol, illegal};

  // Field order: state pcen irwrite regwrite memwrite iord regdst memtoreg alusrca alusrcb pcsrc alu illegal
  function automatic logic [19:0] ev(input logic [3:0] st, input logic pc, input logic ir,
                                     input logic rw, input logic mw, input logic id,
                                     input logic rd, input logic m2r, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [2:0] alu, input logic il);
    return {st, pc, ir, rw, mw, id, rd, m2r, sa, sb, ps, alu, il};
  endfunction

  task automatic apply_stimulus(input string name, input logic r, input logic [5:0] o,
                                input logic [5:0] f, input logic z, input logic mr,
                                input logic [19:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; op = o; funct = f; zero = z; mem_ready = mr;
    e.name = name;
    e.vec  = expv;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    total++;
    if (act !== e.vec) begin
      bad++;
      $display("[TB] FAIL %s: actual=%05h required=%05h", e.name, act, e.vec);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check_output(cur);
    end
  end

  initial begin
    for (int i = 0; i < 10; i++)
      apply_stimulus("reset_hold", 0, OP_LW, 6'd0, 0, 1, ev(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));

    // lw, 5 cycles
    apply_stimulus("lw_fetch",  1, OP_LW, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("lw_decode", 1, OP_LW, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("lw_memadr", 1, OP_LW, 6'd0, 0, 1, ev(2,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
    apply_stimulus("lw_memrd",  1, OP_LW, 6'd0, 0, 1, ev(3,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0));
    apply_stimulus("lw_memwb",  1, OP_LW, 6'd0, 0, 1, ev(4,0,0,1,0,0,0,1,0,2'b00,2'b00,3'b010,0));

    // sw with three stall cycles in MEMWR
    apply_stimulus("sw_fetch",  1, OP_SW, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("sw_decode", 1, OP_SW, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("sw_memadr", 1, OP_SW, 6'd0, 0, 0, ev(2,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
    apply_stimulus("sw_wr_w1",  1, OP_SW, 6'd0, 0, 0, ev(5,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0));
    apply_stimulus("sw_wr_w2",  1, OP_SW, 6'd0, 0, 0, ev(5,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0));
    apply_stimulus("sw_wr_w3",  1, OP_SW, 6'd0, 0, 0, ev(5,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0));
    apply_stimulus("sw_wr_rdy", 1, OP_SW, 6'd0, 0, 1, ev(5,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0));

    // fetch stall, then R-type sub
    apply_stimulus("fetch_stall", 1, OP_R, 6'b100010, 0, 0, ev(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("sub_fetch",   1, OP_R, 6'b100010, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("sub_decode",  1, OP_R, 6'b100010, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("sub_exec",    1, OP_R, 6'b100010, 0, 1, ev(6,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0));
    apply_stimulus("sub_aluwb",   1, OP_R, 6'b100010, 0, 1, ev(7,0,0,1,0,0,1,0,0,2'b00,2'b00,3'b010,0));

    // slt and 'and' decode in EXECUTE
    apply_stimulus("slt_fetch",   1, OP_R, 6'b101010, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("slt_decode",  1, OP_R, 6'b101010, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("slt_exec",    1, OP_R, 6'b101010, 0, 1, ev(6,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0));
    apply_stimulus("slt_aluwb",   1, OP_R, 6'b101010, 0, 1, ev(7,0,0,1,0,0,1,0,0,2'b00,2'b00,3'b010,0));
    apply_stimulus("and_fetch",   1, OP_R, 6'b100100, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("and_decode",  1, OP_R, 6'b100100, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("and_exec",    1, OP_R, 6'b100100, 0, 1, ev(6,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0));
    apply_stimulus("and_aluwb",   1, OP_R, 6'b100100, 0, 1, ev(7,0,0,1,0,0,1,0,0,2'b00,2'b00,3'b010,0));

    // unsupported funct: illegal pulse, no writeback
    apply_stimulus("badf_fetch",  1, OP_R, 6'b000111, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("badf_decode", 1, OP_R, 6'b000111, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("badf_exec",   1, OP_R, 6'b000111, 0, 1, ev(6,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,1));

    // beq taken / not taken
    apply_stimulus("beq1_fetch",  1, OP_BEQ, 6'd0, 1, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("beq1_decode", 1, OP_BEQ, 6'd0, 1, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("beq1_branch", 1, OP_BEQ, 6'd0, 1, 1, ev(8,1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
    apply_stimulus("beq0_fetch",  1, OP_BEQ, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("beq0_decode", 1, OP_BEQ, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("beq0_branch", 1, OP_BEQ, 6'd0, 0, 1, ev(8,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));

    // addi
    apply_stimulus("addi_fetch",  1, OP_ADI, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("addi_decode", 1, OP_ADI, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("addi_exec",   1, OP_ADI, 6'd0, 0, 1, ev(9,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
    apply_stimulus("addi_wb",     1, OP_ADI, 6'd0, 0, 1, ev(10,0,0,1,0,0,0,0,0,2'b00,2'b00,3'b010,0));

    // jump
    apply_stimulus("j_fetch",     1, OP_J, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("j_decode",    1, OP_J, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("j_jump",      1, OP_J, 6'd0, 0, 1, ev(11,1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0));

    // unsupported opcode
    apply_stimulus("badop_fetch",  1, OP_BAD, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("badop_decode", 1, OP_BAD, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1));

    // reset asserted in the middle of a store
    apply_stimulus("swr_fetch",  1, OP_SW, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("swr_decode", 1, OP_SW, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
    apply_stimulus("swr_memadr", 1, OP_SW, 6'd0, 0, 0, ev(2,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
    apply_stimulus("swr_wr",     1, OP_SW, 6'd0, 0, 0, ev(5,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010,0));
    apply_stimulus("swr_abort",  0, OP_SW, 6'd0, 0, 0, ev(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("swr_held",   0, OP_SW, 6'd0, 0, 1, ev(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("swr_refetch",1, OP_LW, 6'd0, 0, 1, ev(0,1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    apply_stimulus("swr_decode2",1, OP_LW, 6'd0, 0, 1, ev(1,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: actual=%0d pending required=0 pending", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
